// File: rtl/noc_pkg.sv
// Shared flit-format constants, flit/packet state enums and the XY route function
// for the NoC input buffer.
package noc_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    HEAD   = 2'b01,
    BODY   = 2'b10,
    TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } pkt_state_e;

  localparam int TYPE_MSB    = 15;
  localparam int TYPE_LSB    = 14;
  localparam int DX_MSB      = 13;
  localparam int DY_MSB      = 9;
  localparam int COORD_MAX_W = 8;

  localparam logic [4:0] R_L = 5'b10000;
  localparam logic [4:0] R_N = 5'b01000;
  localparam logic [4:0] R_S = 5'b00100;
  localparam logic [4:0] R_E = 5'b00010;
  localparam logic [4:0] R_W = 5'b00001;

  // Dimension-order routing: resolve X first, then Y (Y grows southward).
  function automatic logic [4:0] xy_route(input logic [COORD_MAX_W-1:0] dest_x,
                                          input logic [COORD_MAX_W-1:0] dest_y,
                                          input logic [COORD_MAX_W-1:0] my_x,
                                          input logic [COORD_MAX_W-1:0] my_y);
    logic [4:0] r;
    if (dest_x > my_x)      r = R_E;
    else if (dest_x < my_x) r = R_W;
    else if (dest_y > my_y) r = R_S;
    else if (dest_y < my_y) r = R_N;
    else                    r = R_L;
    return r;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Circular buffer of DEPTH x DATA_W entries. The caller gates push so that a
// push while full only happens together with a pop.
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/noc_input_buffer.sv
// Credit-based router input stage: FIFO, XY route of the head flit, packet FSM.
// Define NOC_IBUF_CHECK_EN to enable the sticky protocol/overflow error flag.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int COORD_W = 4,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              credit_o,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [4:0]        route_o,
  input  logic              pop_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  head_flit;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push_en, pop_en;
  flit_type_e         head_type;
  logic [COORD_W-1:0] dest_x, dest_y;
  logic [4:0]         head_route;

  pkt_state_e state_q, state_d;
  logic [4:0] route_q, route_d;
  logic       credit_q, credit_d;

  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign pop_en  = pop_i & ~fifo_empty;
  assign push_en = valid_i & (~fifo_full | pop_en);

  noc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .wdata_i (data_i),
    .rdata_o (head_flit),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_type  = flit_type_e'(head_flit[TYPE_MSB:TYPE_LSB]);
  assign dest_x     = head_flit[DX_MSB -: COORD_W];
  assign dest_y     = head_flit[DY_MSB -: COORD_W];
  assign head_route = xy_route(COORD_MAX_W'(dest_x), COORD_MAX_W'(dest_y),
                               COORD_MAX_W'(MY_X), COORD_MAX_W'(MY_Y));

  always_comb begin
    state_d  = state_q;
    route_d  = route_q;
    credit_d = pop_en;
    if (pop_en) begin
      case (state_q)
        IDLE: begin
          if (head_type == HEAD) begin
            state_d = PKT;
            route_d = head_route;
          end
        end
        PKT: begin
          if (head_type == TAIL) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      route_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      credit_q <= credit_d;
    end
  end

  assign valid_o  = ~fifo_empty;
  assign data_o   = (fifo_count != '0) ? head_flit : '0;
  assign route_o  = fifo_empty ? 5'b0 : ((state_q == PKT) ? route_q : head_route);
  assign credit_o = credit_q;

`ifdef NOC_IBUF_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (valid_i && fifo_full && !pop_en) err_d = 1'b1;
    if (pop_en) begin
      if (state_q == IDLE && (head_type == BODY || head_type == TAIL))   err_d = 1'b1;
      if (state_q == PKT  && (head_type == SINGLE || head_type == HEAD)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Randomized self-checking bench for noc_input_buffer against a queue-based model.
// Honours NOC_IBUF_CHECK_EN for the expected err_o behaviour.
module tb_noc_input_buffer;
  import noc_pkg::*;

  localparam int DEPTH = 4;
  localparam int MY_X  = 0;
  localparam int MY_Y  = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        pop_i = 1'b0;
  logic        credit_o, valid_o, err_o;
  logic [15:0] data_o;
  logic [4:0]  route_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] mq[$];
  bit          m_pkt;
  logic [4:0]  m_route;
  bit          m_credit;
  bit          m_err;

  always #5 clk = ~clk;

  noc_input_buffer #(
    .DATA_W (16), .DEPTH (DEPTH), .COORD_W (4), .MY_X (MY_X), .MY_Y (MY_Y)
  ) dut (
    .clk (clk), .reset (reset), .data_i (data_i), .valid_i (valid_i),
    .credit_o (credit_o), .data_o (data_o), .valid_o (valid_o),
    .route_o (route_o), .pop_i (pop_i), .err_o (err_o)
  );

  function automatic logic [15:0] mk(input logic [1:0] t, input int dx, input int dy, input int pl);
    logic [3:0] x4, y4;
    logic [5:0] p6;
    x4 = 4'(dx);
    y4 = 4'(dy);
    p6 = 6'(pl);
    return {t, x4, y4, p6};
  endfunction

  function automatic logic [4:0] ref_route(input logic [15:0] f);
    int dx, dy;
    dx = int'(f[13:10]);
    dy = int'(f[9:6]);
    if (dx > MY_X) return 5'b00010;
    if (dx < MY_X) return 5'b00001;
    if (dy > MY_Y) return 5'b00100;
    if (dy < MY_Y) return 5'b01000;
    return 5'b10000;
  endfunction

  // Expected {valid, data, route, credit, err} as seen between clock edges.
  function automatic logic [23:0] exp_out();
    logic       v;
    logic [15:0] d;
    logic [4:0]  r;
    v = (mq.size() > 0);
    d = '0;
    r = '0;
    if (v) begin
      d = mq[0];
      r = m_pkt ? m_route : ref_route(mq[0]);
    end
    return {v, d, r, m_credit, m_err};
  endfunction

  task automatic model_update(input logic v, input logic [15:0] d, input logic p);
    bit          pop_ok, push_ok;
    logic [1:0]  t;
    logic [15:0] head;
    pop_ok  = p && (mq.size() > 0);
    push_ok = v && ((mq.size() < DEPTH) || pop_ok);
`ifdef NOC_IBUF_CHECK_EN
    if (v && mq.size() == DEPTH && !pop_ok) m_err = 1'b1;
    if (pop_ok) begin
      t = mq[0][15:14];
      if (!m_pkt && t[1])  m_err = 1'b1;
      if (m_pkt  && !t[1]) m_err = 1'b1;
    end
`endif
    if (pop_ok) begin
      head = mq.pop_front();
      t = head[15:14];
      if (!m_pkt && t == 2'b01) begin
        m_pkt   = 1'b1;
        m_route = ref_route(head);
      end else if (m_pkt && t == 2'b11) begin
        m_pkt = 1'b0;
      end
    end
    if (push_ok) mq.push_back(d);
    m_credit = pop_ok;
  endtask

  task automatic model_clear();
    mq.delete();
    m_pkt    = 1'b0;
    m_route  = '0;
    m_credit = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic tick(input logic v, input logic [15:0] d, input logic p);
    valid_i = v;
    data_i  = d;
    pop_i   = p;
    @(posedge clk);
    model_update(v, d, p);
    @(negedge clk);
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    pop_i   = 1'b0;
    data_i  = '0;
    reset   = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    if ({valid_o, data_o, route_o, credit_o, err_o} !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", {valid_o, data_o, route_o, credit_o, err_o}, 24'h0);
    end
    checks++;
    if (dut.u_fifo.count_o !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_count got=%0d want=0", dut.u_fifo.count_o);
    end
    checks++;
  endtask

  task automatic test_fill();
    logic [23:0] exp;
    int credits;
    do_reset();
    credits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 16'($urandom), 1'b0);
      exp = exp_out();
      credits += credit_o;
      if ({valid_o, data_o, route_o, credit_o, err_o} !== exp || valid_o !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fill_step%0d got=%h want=%h", i, {valid_o, data_o, route_o, credit_o, err_o}, exp);
      end
      checks++;
    end
    if (dut.u_fifo.count_o !== 3'(DEPTH) || credits != 0) begin
      failures++;
      $display("[TB] FAIL fill_count got=%0d credits=%0d want=%0d credits=0", dut.u_fifo.count_o, credits, DEPTH);
    end
    checks++;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      exp = exp_out();
      if ({valid_o, data_o, route_o, credit_o, err_o} !== exp) begin
        failures++;
        $display("[TB] FAIL drain_step%0d got=%h want=%h", i, {valid_o, data_o, route_o, credit_o, err_o}, exp);
      end
      checks++;
    end
  endtask

  task automatic test_packet_route();
    logic [15:0] flits [3];
    logic [23:0] exp;
    int credits;
    do_reset();
    flits[0] = mk(2'b01, 2, 0, 5);
    flits[1] = mk(2'b10, 0, 0, 17);
    flits[2] = mk(2'b11, 0, 0, 33);
    credits = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) tick(1'b1, flits[i], 1'b1);
      else       tick(1'b0, 16'h0, (i == 3));
      exp = exp_out();
      credits += credit_o;
      if ({valid_o, data_o, route_o, credit_o, err_o} !== exp || (valid_o && route_o !== 5'b00010)) begin
        failures++;
        $display("[TB] FAIL packet_step%0d got=%h want=%h", i, {valid_o, data_o, route_o, credit_o, err_o}, exp);
      end
      checks++;
    end
    if (credits != 3 || dut.state_q !== IDLE) begin
      failures++;
      $display("[TB] FAIL packet_end got credits=%0d state=%0d want credits=3 state=0", credits, dut.state_q);
    end
    checks++;
  endtask

  task automatic test_single();
    int credits;
    do_reset();
    tick(1'b1, mk(2'b00, 0, 0, 9), 1'b0);
    if (route_o !== 5'b10000 || {valid_o, data_o, route_o, credit_o, err_o} !== exp_out()) begin
      failures++;
      $display("[TB] FAIL single_route got=%b want=10000", route_o);
    end
    checks++;
    credits = 0;
    tick(1'b0, 16'h0, 1'b1);
    credits += credit_o;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 16'h0, 1'b0);
      credits += credit_o;
    end
    if (credits != 1 || dut.state_q !== IDLE || valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_after got credits=%0d state=%0d valid=%b want 1/0/0", credits, dut.state_q, valid_o);
    end
    checks++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] x;
    logic [23:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, mk(2'b10, i, i, i), 1'b0);
    x = mk(2'b10, 7, 9, 42);
    tick(1'b1, x, 1'b1);
    if (dut.u_fifo.count_o !== 3'(DEPTH) || {valid_o, data_o, route_o, credit_o, err_o} !== exp_out()) begin
      failures++;
      $display("[TB] FAIL fullpp_count got=%0d want=%0d", dut.u_fifo.count_o, DEPTH);
    end
    checks++;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      exp = exp_out();
      if ({valid_o, data_o, route_o, credit_o, err_o} !== exp || (i == DEPTH - 2 && data_o !== x)) begin
        failures++;
        $display("[TB] FAIL fullpp_pop%0d got=%h want=%h", i, {valid_o, data_o, route_o, credit_o, err_o}, exp);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    tick(1'b1, mk(2'b01, 1, 0, 3), 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b1, mk(2'b10, 0, 0, 4), 1'b0);
    valid_i = 1'b0;
    pop_i   = 1'b0;
    #2 reset = 1'b0;
    model_clear();
    #1;
    if (valid_o !== 1'b0 || dut.state_q !== IDLE || route_o !== 5'b0 || data_o !== 16'h0) begin
      failures++;
      $display("[TB] FAIL midreset got valid=%b state=%0d route=%b want 0/0/00000", valid_o, dut.state_q, route_o);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, mk(2'b01, 0, 3, 1), 1'b0);
    if (route_o !== 5'b00100 || {valid_o, data_o, route_o, credit_o, err_o} !== exp_out()) begin
      failures++;
      $display("[TB] FAIL midreset_route got=%b want=00100", route_o);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [23:0] exp;
    logic        v, p;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      p = ($urandom_range(0, 99) < 50);
      tick(v, 16'($urandom), p);
      exp = exp_out();
      if ({valid_o, data_o, route_o, credit_o, err_o} !== exp) begin
        failures++;
        $display("[TB] FAIL random_cyc%0d got=%h want=%h", i, {valid_o, data_o, route_o, credit_o, err_o}, exp);
      end
      checks++;
    end
  endtask

  task automatic test_error();
    logic expect_err;
`ifdef NOC_IBUF_CHECK_EN
    expect_err = 1'b1;
`else
    expect_err = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, mk(2'b00, 0, 0, i), 1'b0);
    tick(1'b1, mk(2'b00, 0, 0, 63), 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (err_o !== expect_err || {valid_o, data_o, route_o, credit_o, err_o} !== exp_out()) begin
        failures++;
        $display("[TB] FAIL err_overflow%0d got=%b want=%b", i, err_o, expect_err);
      end
      checks++;
      tick(1'b0, 16'h0, 1'b0);
    end
    do_reset();
    tick(1'b1, mk(2'b10, 0, 0, 1), 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    tick(1'b0, 16'h0, 1'b0);
    if (err_o !== expect_err || {valid_o, data_o, route_o, credit_o, err_o} !== exp_out()) begin
      failures++;
      $display("[TB] FAIL err_body_idle got=%b want=%b", err_o, expect_err);
    end
    checks++;
    do_reset();
    if (err_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_cleared got=%b want=0", err_o);
    end
    checks++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_packet_route();
    test_single();
    test_full_push_pop();
    test_reset_mid_packet();
    test_random();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
